// File: rtl/formula_collector_pkg.sv
// Shared defaults, tag/result types and the lane priority helper
// for the formula result collector.
package formula_collector_pkg;

    localparam int FC_N_LANES = 4;
    localparam int FC_WIDTH   = 32;
    localparam int FC_DEPTH   = 8;
    localparam int FC_TAG_W   = $clog2(FC_DEPTH);

    typedef logic [FC_TAG_W-1:0] tag_t;
    typedef logic [FC_WIDTH-1:0] res_t;

    // One-hot of the lowest-index valid lane carrying the given tag.
    function automatic logic [FC_N_LANES-1:0] lane_sel(
        input logic [FC_N_LANES-1:0]          vld,
        input logic [FC_N_LANES*FC_TAG_W-1:0] tags,
        input tag_t                           tag
    );
        logic [FC_N_LANES-1:0] sel;
        logic                  found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < FC_N_LANES; i++) begin
            if (!found && vld[i] &&
                tags[i*FC_TAG_W +: FC_TAG_W] == tag) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/formula_collector_slot.sv
// One reorder entry: alloc on set, data+valid on wr, both cleared on clr.
// Ports: clk, rst (async active-low), set, wr, wdata, clr -> alloc, valid, data.
module formula_collector_slot
    import formula_collector_pkg::*;
#(
    parameter int WIDTH = FC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr,
    output logic             alloc,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc <= 1'b0;
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (set) begin
                alloc <= 1'b1;
            end else if (clr) begin
                alloc <= 1'b0;
            end
            // wr only happens while !valid, clr only while valid
            if (wr) begin
                valid <= 1'b1;
                data  <= wdata;
            end else if (clr) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/formula_result_collector.sv
// Tags issues, collects out-of-order lane results, emits them in issue order.
// Ports: issue_vld/rdy/tag, lane_vld/tag/res, res_vld/rdy/res, sticky err.
module formula_result_collector
    import formula_collector_pkg::*;
#(
    parameter  int N_LANES = FC_N_LANES,
    parameter  int WIDTH   = FC_WIDTH,
    parameter  int DEPTH   = FC_DEPTH,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_vld,
    output logic                     issue_rdy,
    output logic [TAG_W-1:0]         issue_tag,
    input  logic [N_LANES-1:0]       lane_vld,
    input  logic [N_LANES*TAG_W-1:0] lane_tag,
    input  logic [N_LANES*WIDTH-1:0] lane_res,
    output logic                     res_vld,
    input  logic                     res_rdy,
    output logic [WIDTH-1:0]         res,
    output logic                     err
);

    logic [TAG_W-1:0]   wr_ptr;
    logic [TAG_W-1:0]   rd_ptr;
    logic [TAG_W:0]     count;
    logic [DEPTH-1:0]   alloc;
    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0]   set;
    logic [DEPTH-1:0]   wr;
    logic [DEPTH-1:0]   clr;
    logic [WIDTH-1:0]   data  [DEPTH];
    logic [WIDTH-1:0]   wdata [DEPTH];
    logic [N_LANES-1:0] sel_m [DEPTH];
    logic               do_issue;
    logic               do_retire;
    logic               err_set;

    assign issue_rdy = (count != (TAG_W+1)'(DEPTH));
    assign issue_tag = wr_ptr;
    assign do_issue  = issue_vld & issue_rdy;
    assign res_vld   = valid[rd_ptr];
    assign res       = res_vld ? data[rd_ptr] : '0;
    assign do_retire = res_vld & res_rdy;

    always_comb begin
        err_set = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            sel_m[s] = lane_sel(lane_vld, lane_tag, TAG_W'(s));
            wr[s]    = (|sel_m[s]) & alloc[s] & ~valid[s];
            set[s]   = do_issue & (wr_ptr == TAG_W'(s));
            clr[s]   = do_retire & (rd_ptr == TAG_W'(s));
            wdata[s] = '0;
            for (int i = 0; i < N_LANES; i++) begin
                if (sel_m[s][i]) begin
                    wdata[s] = wdata[s] | lane_res[i*WIDTH +: WIDTH];
                end
            end
        end
        // A lane is flagged unless it is the winning writer of a free slot
        for (int i = 0; i < N_LANES; i++) begin
            if (lane_vld[i]) begin
                if (!(alloc[lane_tag[i*TAG_W +: TAG_W]] &&
                      !valid[lane_tag[i*TAG_W +: TAG_W]] &&
                      sel_m[lane_tag[i*TAG_W +: TAG_W]][i])) begin
                    err_set = 1'b1;
                end
            end
        end
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        formula_collector_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst   (rst),
            .set   (set[s]),
            .wr    (wr[s]),
            .wdata (wdata[s]),
            .clr   (clr[s]),
            .alloc (alloc[s]),
            .valid (valid[s]),
            .data  (data[s])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (do_issue) begin
                wr_ptr <= wr_ptr + TAG_W'(1);
            end
            if (do_retire) begin
                rd_ptr <= rd_ptr + TAG_W'(1);
            end
            unique case ({do_issue, do_retire})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule
